// File: rtl/vcpu_mem_io.sv
// CPU data memory with a memory-mapped I/O window: synchronous RAM, output ports,
// synchronised input pins, write-1-to-clear rising-edge flags and a maskable interrupt.
module vcpu_mem_io #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 512,
  parameter int unsigned IO_BASE    = 'hFF00,
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned NUM_IN     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic [DATA_WIDTH-1:0]          data,
  output logic [DATA_WIDTH-1:0]          q,
  output logic [NUM_OUT*DATA_WIDTH-1:0]  ports,
  input  logic [NUM_IN*DATA_WIDTH-1:0]   pins,
  output logic                           irq
);

  localparam int unsigned RamAw = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] IoBase = ADDR_WIDTH'(IO_BASE);
  localparam logic [ADDR_WIDTH-1:0] RamTop = ADDR_WIDTH'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem     [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] portReg [NUM_OUT];
  logic [DATA_WIDTH-1:0] sync1   [NUM_IN];
  logic [DATA_WIDTH-1:0] sync2   [NUM_IN];
  logic [DATA_WIDTH-1:0] prev    [NUM_IN];
  logic [DATA_WIDTH-1:0] flags   [NUM_IN];
  logic [DATA_WIDTH-1:0] mask    [NUM_IN];
  logic [DATA_WIDTH-1:0] flagsNext [NUM_IN];

  logic [ADDR_WIDTH-1:0] off;
  logic [RamAw-1:0]      ramIdx;
  logic                  isRam;
  logic                  inWindow;
  logic [DATA_WIDTH-1:0] readData;
  logic                  irqNext;

  always_comb begin
    off      = address - IoBase;
    ramIdx   = address[RamAw-1:0];
    isRam    = address < RamTop;
    inWindow = address >= IoBase;
    readData = '0;
    if (isRam) begin
      readData = mem[ramIdx];
    end else if (inWindow) begin
      for (int unsigned p = 0; p < NUM_OUT; p++) begin
        if (off == ADDR_WIDTH'(p)) readData = portReg[p];
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (off == ADDR_WIDTH'(32'h10 + i)) readData = sync2[i];
        if (off == ADDR_WIDTH'(32'h20 + i)) readData = flags[i];
        if (off == ADDR_WIDTH'(32'h30 + i)) readData = mask[i];
      end
    end
  end

  // A newly detected edge overrides a simultaneous clear of the same bit.
  always_comb begin
    irqNext = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      flagsNext[i] = flags[i] & ~((we && inWindow && off == ADDR_WIDTH'(32'h20 + i)) ?
                                  data : '0);
      flagsNext[i] = flagsNext[i] | (sync2[i] & ~prev[i]);
      irqNext      = irqNext | (|(flags[i] & mask[i]));
    end
  end

  // RAM is not reset and still accepts writes while reset is asserted.
  always_ff @(posedge clk) begin
    if (we && isRam) mem[ramIdx] <= data;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      sync1[i] <= pins[i*DATA_WIDTH +: DATA_WIDTH];
      sync2[i] <= sync1[i];
      prev[i]  <= sync2[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      irq <= 1'b0;
      for (int unsigned p = 0; p < NUM_OUT; p++) portReg[p] <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        flags[i] <= '0;
        mask[i]  <= '0;
      end
    end else begin
      q   <= readData;
      irq <= irqNext;
      for (int unsigned p = 0; p < NUM_OUT; p++) begin
        if (we && inWindow && off == ADDR_WIDTH'(p)) portReg[p] <= data;
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        flags[i] <= flagsNext[i];
        if (we && inWindow && off == ADDR_WIDTH'(32'h30 + i)) mask[i] <= data;
      end
    end
  end

  for (genvar p = 0; p < NUM_OUT; p++) begin : gPorts
    assign ports[p*DATA_WIDTH +: DATA_WIDTH] = portReg[p];
  end

endmodule

// File: tb/tb_vcpu_mem_io.sv
// Directed and randomised bench for vcpu_mem_io against a map-level reference model.
module tb_vcpu_mem_io;

  logic        clk = 1'b0;
  logic        reset, we;
  logic [15:0] address;
  logic [7:0]  data;
  logic [7:0]  q;
  logic [15:0] ports;
  logic [15:0] pins;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference state: memory map contents plus the history of pin samples per edge.
  logic [7:0]  mram [512];
  logic [15:0] mports, mflags, mmask;
  logic        mirq;
  logic [15:0] s1, s2, s3;  // pins sampled 1, 2, 3 edges ago

  vcpu_mem_io dut (
    .clk(clk), .reset(reset), .we(we), .address(address), .data(data),
    .q(q), .ports(ports), .pins(pins), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What a read of addr returns given the state before the edge.
  function automatic logic [7:0] mread(input logic [15:0] a);
    if (a < 16'd512) return mram[a[8:0]];
    case (a)
      16'hFF00: return mports[7:0];
      16'hFF01: return mports[15:8];
      16'hFF10: return s2[7:0];
      16'hFF11: return s2[15:8];
      16'hFF20: return mflags[7:0];
      16'hFF21: return mflags[15:8];
      16'hFF30: return mmask[7:0];
      16'hFF31: return mmask[15:8];
      default:  return 8'h00;
    endcase
  endfunction

  task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    logic [7:0]  expQ;
    logic [15:0] clr, rise;
    logic        expIrq;
    @(negedge clk);
    reset = r; we = w; address = a; data = d;
    expQ   = r ? 8'h00 : mread(a);
    expIrq = r ? 1'b0 : |(mflags & mmask);
    rise   = s2 & ~s3;
    clr    = '0;
    if (w && a == 16'hFF20) clr[7:0] = d;
    if (w && a == 16'hFF21) clr[15:8] = d;
    if (w && a < 16'd512) mram[a[8:0]] = d;
    if (r) begin
      mports = '0; mmask = '0; mflags = '0;
    end else begin
      mflags = (mflags & ~clr) | rise;
      if (w && a == 16'hFF00) mports[7:0]  = d;
      if (w && a == 16'hFF01) mports[15:8] = d;
      if (w && a == 16'hFF30) mmask[7:0]   = d;
      if (w && a == 16'hFF31) mmask[15:8]  = d;
    end
    mirq = expIrq;
    s3 = s2; s2 = s1; s1 = pins;
    @(posedge clk);
    #1;
    check("q", {8'h00, q}, {8'h00, expQ});
    check("ports", ports, mports);
    check("irq", {15'd0, irq}, {15'd0, mirq});
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] ioAddrs [10];
    ioAddrs = '{16'hFF00, 16'hFF01, 16'hFF10, 16'hFF11, 16'hFF20,
                16'hFF21, 16'hFF30, 16'hFF31, 16'hFF05, 16'hFE00};
    reset = 1'b1; we = 1'b0; address = '0; data = '0; pins = '0;
    mports = '0; mflags = '0; mmask = '0; mirq = 1'b0;
    s1 = '0; s2 = '0; s3 = '0;

    repeat (4) step(1, 0, 16'h0000, 8'h00);

    // RAM fill and readback, then the first unmapped address
    step(0, 1, 16'd0, 8'h55);
    step(0, 1, 16'd1, 8'hFF);
    for (int i = 2; i < 512; i++) step(0, 1, 16'(i), 8'h23);
    for (int i = 0; i < 512; i++) step(0, 0, 16'(i), 8'h00);
    step(0, 0, 16'd512, 8'h00);
    check("unmapped512", {8'h00, q}, 16'h0000);

    // Read-first on same-address write
    step(0, 1, 16'd5, 8'h11);
    step(0, 1, 16'd5, 8'h22);
    check("rdw_old", {8'h00, q}, 16'h0011);
    step(0, 0, 16'd5, 8'h00);
    check("rdw_new", {8'h00, q}, 16'h0022);

    // Output ports, readback, then reset
    step(0, 1, 16'hFF00, 8'hA5);
    step(0, 1, 16'hFF01, 8'h3C);
    check("ports_val", ports, 16'h3CA5);
    step(0, 0, 16'hFF00, 8'h00);
    step(0, 0, 16'hFF01, 8'h00);
    check("port1_rd", {8'h00, q}, 16'h003C);
    repeat (3) step(1, 0, 16'h0000, 8'h00);
    check("ports_rst", ports, 16'h0000);
    step(0, 0, 16'd0, 8'h00);
    check("ram_keep", {8'h00, q}, 16'h0055);

    // Pin sync and edge flags
    pins = 16'h0081;
    repeat (4) step(0, 0, 16'hFF10, 8'h00);
    check("sync_rd", {8'h00, q}, 16'h0081);
    step(0, 0, 16'hFF20, 8'h00);
    check("flags_set", {8'h00, q}, 16'h0081);
    step(0, 1, 16'hFF20, 8'h01);
    step(0, 0, 16'hFF20, 8'h00);
    check("flags_w1c", {8'h00, q}, 16'h0080);

    // Set beats clear: bit 1 rises on the same edge as its clear
    pins = 16'h0083;
    step(0, 0, 16'h0000, 8'h00);
    step(0, 0, 16'h0000, 8'h00);
    step(0, 1, 16'hFF20, 8'h02);
    step(0, 0, 16'hFF20, 8'h00);
    check("set_wins", {8'h00, q}, 16'h0082);

    // Interrupt masking
    step(0, 1, 16'hFF20, 8'h02);
    step(0, 0, 16'h0000, 8'h00);
    check("irq_masked", {15'd0, irq}, 16'h0000);
    step(0, 1, 16'hFF30, 8'h80);
    step(0, 0, 16'h0000, 8'h00);
    check("irq_on", {15'd0, irq}, 16'h0001);
    step(0, 1, 16'hFF20, 8'h80);
    step(0, 0, 16'h0000, 8'h00);
    check("irq_off", {15'd0, irq}, 16'h0000);
    pins = 16'h0001;
    repeat (3) step(0, 0, 16'h0000, 8'h00);
    pins = 16'h0081;
    repeat (4) step(0, 0, 16'h0000, 8'h00);
    check("irq_again", {15'd0, irq}, 16'h0001);
    step(1, 0, 16'h0000, 8'h00);
    check("irq_rst", {15'd0, irq}, 16'h0000);
    repeat (2) step(1, 0, 16'h0000, 8'h00);

    // Randomised traffic, pin activity and occasional resets
    pins = 16'hFFFF;
    repeat (3) step(1, 0, 16'h0000, 8'h00);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) pins = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 16'($urandom_range(0, 511));
        1:       ra = 16'($urandom_range(512, 16'hFEFF));
        default: ra = ioAddrs[$urandom_range(0, 9)];
      endcase
      if ($urandom_range(0, 99) == 0) begin
        repeat (3) step(1, 1'($urandom), ra, 8'($urandom));
      end else begin
        step(0, 1'($urandom), ra, 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vcpu_mem_io.md
Name: vcpu_mem_io

Overview:
- Parametrised successor to the CPU data memory: single-port synchronous RAM plus a memory-mapped I/O window.
- Generalises address/data width, RAM depth and number of output ports and input pin groups.
- Adds registered reads, 2-flop input synchronisers, rising-edge flag registers (write-1-to-clear) and a maskable interrupt output.
- Sits between the CPU core bus and the board GPIO.

Parameters:
ADDR_WIDTH, 16, CPU address bus width.
DATA_WIDTH, 8, data bus and port width.
RAM_DEPTH, 512, RAM words at addresses 0..RAM_DEPTH-1; must be at most IO_BASE.
IO_BASE, 'hFF00, base address of the I/O window.
NUM_OUT, 2, number of output ports (1..16).
NUM_IN, 2, number of input pin groups (1..16).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
we  in  1  write enable, sampled at clk edge.
address  in  ADDR_WIDTH  word address.
data  in  DATA_WIDTH  write data.
q  out  DATA_WIDTH  registered read data.
ports  out  NUM_OUT*DATA_WIDTH  output port registers; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
pins  in  NUM_IN*DATA_WIDTH  asynchronous input pin groups, same packing.
irq  out  1  registered interrupt request.

Behaviour:
- Reset values: q=0, ports=0, all edge flags=0, all masks=0, irq=0.
- RAM contents are not cleared by reset.
- Synchroniser chain (sync1, sync2, prev) is not reset and keeps sampling pins during reset.
- Reset must be held at least 3 cycles.
- Address decode, with off = address - IO_BASE:
  - address < RAM_DEPTH: RAM word.
  - RAM_DEPTH <= address < IO_BASE: unmapped; reads 0, writes ignored.
  - off = p, p < NUM_OUT: port register p, read/write.
  - off = 'h10+i, i < NUM_IN: synchronised pin value, read-only; writes ignored.
  - off = 'h20+i: edge flag register i; read returns flags; write clears each bit where data is 1.
  - off = 'h30+i: interrupt mask register i, read/write.
  - Any other offset in the window: reads 0, writes ignored.
- Writes: when we=1 at a clk edge, the target register or RAM word updates at that edge. ports reflects the new value right after that edge.
- Reads:
  - q updates every edge (no read enable) with the data at address sampled on that edge, so latency is 1 cycle.
  - Read-first: a read and write to the same address on the same edge return the old value.
- Pin sampling, per bit: sync1<=pins; sync2<=sync1; prev<=sync2.
  - A pin change set up before edge k appears in sync2 (readable) after edge k+1.
- Edge flags:
  - The flag bit sets at the edge where sync2=1 and prev=0, i.e. edge k+2 for a 0->1 change.
  - Set wins over a simultaneous write-1-to-clear of the same bit.
  - Flags are held at 0 while reset=1.
  - Pins high throughout reset produce no flag after release.
- irq <= OR over all i of (flags[i] & mask[i]), registered.
  - irq asserts one edge after the flag/mask condition becomes true.
  - irq deasserts one edge after the condition is cleared.
- Reset mid-operation:
  - A write on the same edge as reset=1 is ignored for ports/flags/masks.
  - RAM writes with reset=1 still occur.
  - q is forced to 0.
- Arithmetic: off is computed in ADDR_WIDTH bits. Addresses below IO_BASE never alias into the window.

Test Plan:
- RAM fill/readback:
  - Write 'h55 to addr 0, 'hFF to addr 1, 'h23 to addrs 2..511.
  - Read 0..511 -> q shows 55, FF, then 23, each 1 cycle after its address is applied.
  - Read addr 512 -> 0.
- Read-during-write: RAM[5]='h11; write 'h22 to addr 5 with address held -> q='h11 after the write edge, 'h22 one edge later.
- Port write/reset:
  - Write 'hA5 to IO_BASE+0 and 'h3C to IO_BASE+1 -> ports='h3CA5; readback matches.
  - Assert reset 3 cycles -> ports=0, q=0, RAM[0] still 'h55.
- Pin sync and edge flags:
  - pins[7:0] 'h00->'h81 before edge k -> IO_BASE+'h10 reads 'h81 from edge k+1.
  - Flags register IO_BASE+'h20 = 'h81 set at edge k+2.
  - Write 'h01 to IO_BASE+'h20 -> flags read 'h80.
- Set beats clear: time a new rising edge on bit 1 to land on the same edge as a write of 'h02 to IO_BASE+'h20 -> bit 1 remains 1.
- irq masking:
  - Flags 'h80 with mask 0 -> irq=0.
  - Write 'h80 to IO_BASE+'h30 -> irq=1 one edge later.
  - Clear flag -> irq=0 one edge after the clear.
  - Reset asserted while irq=1 -> irq=0 after that edge.
